// File: rtl/word_unpack_pkg.sv
// Shared types and helpers for the word unpacker: FSM state encoding and
// the element-order index mapping.
package word_unpack_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  function automatic int unsigned elem_index(input int unsigned cnt,
                                             input logic        msb_first,
                                             input int unsigned n);
    if (msb_first) begin
      return n - 32'd1 - cnt;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Streams a WIDTH-bit word out as WIDTH/ELEM_W elements over valid/ready,
// with per-word element order and per-element bit reversal.
module word_unpacker
  import word_unpack_pkg::*;
#(
  parameter  int WIDTH  = 64,
  parameter  int ELEM_W = 8,
  localparam int N      = WIDTH / ELEM_W,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_msb_first,
  input  logic              in_rev,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last
);

  if (WIDTH % ELEM_W != 0) begin : g_bad_width
    $error("word_unpacker: WIDTH must be a multiple of ELEM_W");
  end

  state_t                       state_r, state_nxt_s;
  logic [N-1:0][ELEM_W-1:0]     word_r;
  logic                         msb_first_r;
  logic                         rev_r;
  logic [IW-1:0]                cnt_r;
  logic [31:0]                  idx_full_s;
  logic [IW-1:0]                idx_s;
  logic [ELEM_W-1:0]            elem_s;
  logic [ELEM_W-1:0]            elem_rev_s;
  logic                         send_s;
  logic                         last_s;
  logic                         load_s;
  logic                         adv_s;
  logic                         in_ready_s;

  assign send_s     = (state_r == SEND);
  assign last_s     = (cnt_r == IW'(N - 1));
  assign idx_full_s = elem_index(32'(cnt_r), msb_first_r, 32'(N));
  assign idx_s      = idx_full_s[IW-1:0];
  assign elem_s     = word_r[idx_s];
  assign elem_rev_s = {<<{elem_s}};

  // Next-state, load/advance decisions and input-side ready.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    adv_s       = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (out_ready && last_s) begin
          // Ready only on the final beat so the next word follows with no bubble.
          in_ready_s = 1'b1;
          if (in_valid) begin
            load_s      = 1'b1;
            state_nxt_s = SEND;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (out_ready) begin
          adv_s = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, captured word, per-word flags and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      word_r      <= '0;
      msb_first_r <= 1'b0;
      rev_r       <= 1'b0;
      cnt_r       <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        word_r      <= in_data;
        msb_first_r <= in_msb_first;
        rev_r       <= in_rev;
        cnt_r       <= '0;
      end else if (adv_s) begin
        cnt_r <= cnt_r + IW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign in_ready  = rst ? 1'b0 : in_ready_s;
  assign out_valid = send_s;
  assign out_last  = send_s & last_s;
  assign out_idx   = send_s ? idx_s : '0;
  assign out_data  = send_s ? (rev_r ? elem_rev_s : elem_s) : '0;

endmodule
